// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer blitter.
package fb_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 640;
  localparam int unsigned FB_HEIGHT_DEF = 480;
  localparam int unsigned FB_ADDR_W     = 19;

  typedef enum logic {
    OpClear = 1'b0,
    OpBlit  = 1'b1
  } fb_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } fb_blit_state_t;

  // Shift-and-add start-of-row offset; only used once per command.
  function automatic logic [FB_ADDR_W-1:0] row_offset(input logic [8:0] y,
                                                      input int unsigned width);
    logic [FB_ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      if (y[i]) acc = acc + (FB_ADDR_W'(width) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_blit_walker.sv
// Rectangle walker: steps pixel pairs along a row, then down rows, tracking the
// row base address incrementally.
module fb_blit_walker
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH = FB_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 advance,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  input  logic [9:0]           w,
  input  logic [8:0]           h,
  output logic                 last,
  output logic                 pad,
  output logic [10:0]          col,
  output logic [9:0]           row,
  output logic [FB_ADDR_W-1:0] row_base,
  output logic [15:0]          idx
);

  logic [9:0]           x_q;
  logic [9:0]           ppr_q;
  logic [9:0]           k_q;
  logic [8:0]           h_q;
  logic [8:0]           r_q;
  logic                 odd_q;
  logic [10:0]          col_q;
  logic [9:0]           row_q;
  logic [FB_ADDR_W-1:0] row_base_q;
  logic [15:0]          idx_q;
  logic                 row_end;

  assign row_end  = (k_q == ppr_q - 10'd1);
  assign last     = row_end && (r_q == h_q - 9'd1);
  // Odd width: the right pixel of the final pair in each row lies outside the rectangle.
  assign pad      = row_end && odd_q;
  assign col      = col_q;
  assign row      = row_q;
  assign row_base = row_base_q;
  assign idx      = idx_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      ppr_q      <= '0;
      k_q        <= '0;
      h_q        <= '0;
      r_q        <= '0;
      odd_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      idx_q      <= '0;
    end else if (start) begin
      x_q        <= x;
      ppr_q      <= (w >> 1) + {9'b0, w[0]};
      h_q        <= h;
      odd_q      <= w[0];
      k_q        <= '0;
      r_q        <= '0;
      col_q      <= {1'b0, x};
      row_q      <= {1'b0, y};
      row_base_q <= row_offset(y, FB_WIDTH);
      idx_q      <= '0;
    end else if (advance) begin
      idx_q <= idx_q + 16'd1;
      if (row_end) begin
        k_q        <= '0;
        r_q        <= r_q + 9'd1;
        col_q      <= {1'b0, x_q};
        row_q      <= row_q + 10'd1;
        row_base_q <= row_base_q + FB_ADDR_W'(FB_WIDTH);
      end else begin
        k_q   <= k_q + 10'd1;
        col_q <= col_q + 11'd2;
      end
    end
  end

endmodule

// File: rtl/fb_blitter.sv
// Command-driven two-pixel-per-cycle framebuffer writer (CLEAR / BLIT with clipping).
// Optional build macro FB_BLIT_TRANSPARENCY_EN: BLIT skips pixels of value 4'h0.
module fb_blitter
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [9:0]           cmd_x,
  input  logic [8:0]           cmd_y,
  input  logic [9:0]           cmd_w,
  input  logic [8:0]           cmd_h,
  input  logic [15:0]          cmd_base,
  input  logic [3:0]           cmd_color,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          spr_addr,
  input  logic [7:0]           spr_data,
  output logic [FB_ADDR_W-1:0] addr_wr1,
  output logic [FB_ADDR_W-1:0] addr_wr2,
  output logic [3:0]           data_wr1,
  output logic [3:0]           data_wr2,
  output logic                 wr1_en,
  output logic                 wr2_en
);

  localparam logic [11:0] WidthLim  = 12'(FB_WIDTH);
  localparam logic [9:0]  HeightLim = 10'(FB_HEIGHT);

  fb_blit_state_t       state_q, state_d;
  fb_op_t               op_q;
  logic [15:0]          base_q;
  logic [3:0]           color_q;
  logic                 done_q;
  logic                 en1_q, en2_q, blit_q;
  logic [FB_ADDR_W-1:0] addr1_q, addr2_q;

  logic                 accept, run;
  logic                 w_last, w_pad;
  logic [10:0]          w_col;
  logic [9:0]           w_row;
  logic [FB_ADDR_W-1:0] w_row_base;
  logic [15:0]          w_idx;
  logic                 row_ok, col1_ok, col2_ok;
  logic [FB_ADDR_W-1:0] pix_addr;

  assign accept = cmd_valid && (state_q == StIdle);
  assign run    = (state_q == StRun);

  fb_blit_walker #(
    .FB_WIDTH(FB_WIDTH)
  ) u_walker (
    .clock   (clock),
    .reset   (reset),
    .start   (accept),
    .advance (run),
    .x       (cmd_x),
    .y       (cmd_y),
    .w       (cmd_w),
    .h       (cmd_h),
    .last    (w_last),
    .pad     (w_pad),
    .col     (w_col),
    .row     (w_row),
    .row_base(w_row_base),
    .idx     (w_idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (cmd_w != 10'd0 && cmd_h != 9'd0) ? StRun : StDrain;
      end
      StRun: begin
        if (w_last) state_d = StDrain;
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign row_ok   = (w_row < HeightLim);
  assign col1_ok  = ({1'b0, w_col} < WidthLim);
  assign col2_ok  = ({1'b0, w_col} + 12'd1 < WidthLim);
  assign pix_addr = w_row_base + {8'b0, w_col};

  // Pair pipeline stage: issued while spr_addr is out, written when spr_data returns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpClear;
      base_q  <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      blit_q  <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StDrain);
      if (accept) begin
        op_q    <= fb_op_t'(cmd_op);
        base_q  <= cmd_base;
        color_q <= cmd_color;
      end
      en1_q   <= run && row_ok && col1_ok;
      en2_q   <= run && row_ok && col2_ok && !w_pad;
      blit_q  <= run && (op_q == OpBlit);
      addr1_q <= pix_addr;
      addr2_q <= pix_addr + 19'd1;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign spr_addr  = base_q + w_idx;
  assign addr_wr1  = addr1_q;
  assign addr_wr2  = addr2_q;
  assign data_wr1  = blit_q ? spr_data[3:0] : color_q;
  assign data_wr2  = blit_q ? spr_data[7:4] : color_q;

`ifdef FB_BLIT_TRANSPARENCY_EN
  assign wr1_en = en1_q && !(blit_q && spr_data[3:0] == 4'h0);
  assign wr2_en = en2_q && !(blit_q && spr_data[7:4] == 4'h0);
`else
  assign wr1_en = en1_q;
  assign wr2_en = en2_q;
`endif

endmodule

// File: tb/tb_fb_blitter.sv
// Self-checking bench for fb_blitter: directed cases plus random commands checked
// against a per-pair arithmetic model of the rectangle walk.
module tb_fb_blitter;

  localparam int W = 640;
  localparam int H = 480;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [15:0] cmd_base;
  logic [3:0]  cmd_color;
  logic        busy;
  logic        done;
  logic [15:0] spr_addr;
  logic [7:0]  spr_data;
  logic [18:0] addr_wr1, addr_wr2;
  logic [3:0]  data_wr1, data_wr2;
  logic        wr1_en, wr2_en;

  logic [7:0]  rom [65536];

  int n_checks = 0;
  int n_fail   = 0;

  fb_blitter dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_base (cmd_base),
    .cmd_color(cmd_color),
    .busy     (busy),
    .done     (done),
    .spr_addr (spr_addr),
    .spr_data (spr_data),
    .addr_wr1 (addr_wr1),
    .addr_wr2 (addr_wr2),
    .data_wr1 (data_wr1),
    .data_wr2 (data_wr2),
    .wr1_en   (wr1_en),
    .wr2_en   (wr2_en)
  );

  always #5 clock = ~clock;

  // Synchronous sprite ROM: data valid one cycle after the address.
  always @(posedge clock) spr_data <= rom[spr_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected writes for pair p of a command.
  task automatic model_pair(input int op, input int x, input int y, input int w,
                            input int base, input int color, input int p,
                            output bit e1, output bit e2, output int a1, output int a2,
                            output int d1, output int d2);
    int kpr, r, k, row, c1, c2;
    logic [7:0] word;
    kpr  = (w + 1) / 2;
    r    = p / kpr;
    k    = p % kpr;
    row  = y + r;
    c1   = x + 2 * k;
    c2   = c1 + 1;
    a1   = (row * W + c1) % (1 << 19);
    a2   = (row * W + c2) % (1 << 19);
    e1   = (c1 < W) && (row < H);
    e2   = (c2 < W) && (row < H) && (2 * k + 1 != w);
    word = rom[(base + p) % 65536];
    if (op == 1) begin
      d1 = int'(word[3:0]);
      d2 = int'(word[7:4]);
`ifdef FB_BLIT_TRANSPARENCY_EN
      if (d1 == 0) e1 = 1'b0;
      if (d2 == 0) e2 = 1'b0;
`endif
    end else begin
      d1 = color;
      d2 = color;
    end
  endtask

  // Issue one command in the current cycle and check every cycle up to its done pulse.
  task automatic run_cmd(input int op, input int x, input int y, input int w, input int h,
                         input int base, input int color);
    int  np;
    bit  e1, e2;
    int  a1, a2, d1, d2;
    check_eq("ready_pre", 32'(cmd_ready), 32'd1);
    cmd_op    = op[0];
    cmd_x     = x[9:0];
    cmd_y     = y[8:0];
    cmd_w     = w[9:0];
    cmd_h     = h[8:0];
    cmd_base  = base[15:0];
    cmd_color = color[3:0];
    cmd_valid = 1'b1;
    np = ((w + 1) / 2) * h;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= np + 2; c++) begin
      if (c > 1) tick();
      check_eq("busy", 32'(busy), 32'(c <= np + 1));
      check_eq("done", 32'(done), 32'(c == np + 2));
      check_eq("ready", 32'(cmd_ready), 32'(c == np + 2));
      if (c <= np) check_eq("spr_addr", 32'(spr_addr), 32'((base + c - 1) % 65536));
      if (c >= 2 && c <= np + 1) begin
        model_pair(op, x, y, w, base, color, c - 2, e1, e2, a1, a2, d1, d2);
        check_eq("wr1_en", 32'(wr1_en), 32'(e1));
        check_eq("wr2_en", 32'(wr2_en), 32'(e2));
        if (e1) begin
          check_eq("addr_wr1", 32'(addr_wr1), 32'(a1));
          check_eq("data_wr1", 32'(data_wr1), 32'(d1));
        end
        if (e2) begin
          check_eq("addr_wr2", 32'(addr_wr2), 32'(a2));
          check_eq("data_wr2", 32'(data_wr2), 32'(d2));
        end
      end else begin
        check_eq("idle_strobes", 32'({wr1_en, wr2_en}), 32'd0);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    rom[16'h0100] = 8'h21;
    rom[16'h0101] = 8'h03;
    rom[16'h0200] = 8'h70;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_base  = '0;
    cmd_color = '0;
    tick();
    tick();
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_spr_addr", 32'(spr_addr), 32'd0);
    check_eq("rst_strobes", 32'({wr1_en, wr2_en}), 32'd0);
    check_eq("rst_addr", 32'({addr_wr1, addr_wr2}), 32'd0);
    check_eq("rst_data", 32'({data_wr1, data_wr2}), 32'd0);
    reset = 1'b0;
    tick();

    // Directed cases from the rectangle, odd-width, clipping, transparency and empty rules.
    run_cmd(0, 0, 0, 4, 2, 0, 5);
    run_cmd(1, 10, 1, 3, 1, 16'h0100, 0);
    run_cmd(0, 638, 479, 4, 2, 0, 9);
    run_cmd(1, 0, 0, 2, 1, 16'h0200, 0);
    run_cmd(0, 5, 5, 0, 5, 0, 3);
    run_cmd(1, 100, 100, 7, 0, 0, 0);
    run_cmd(1, 1020, 3, 6, 2, 16'hfffe, 0);

    // Random commands, issued back-to-back in the done cycle.
    for (int i = 0; i < 60; i++) begin
      run_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 700)),
              int'($urandom_range(0, 500)), int'($urandom_range(0, 24)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 15)));
    end

    // Reset in the middle of a 16x16 BLIT.
    cmd_op    = 1'b1;
    cmd_x     = 10'd20;
    cmd_y     = 9'd20;
    cmd_w     = 10'd16;
    cmd_h     = 9'd16;
    cmd_base  = 16'h1234;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check_eq("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_strobes", 32'({wr1_en, wr2_en}), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
    tick();
    check_eq("mid_rst_done2", 32'(done), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("post_rst_done", 32'(done), 32'd0);
      check_eq("post_rst_strobes", 32'({wr1_en, wr2_en}), 32'd0);
    end
    run_cmd(0, 30, 40, 5, 3, 0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
